top_k_select: RTL and testbench

Streaming top-K selector that sits directly upstream of the running-mean stage. Consumes one candidate distance per cycle for the current query, keeps the K smallest in an ascending sorted register list, and at end of query pulses `top_k_done` with the K-th smallest distance on `kth_distance`. Those two outputs connect straight to the running-mean inputs of the same names. The list then clears automatically for the next query.

---
 rtl/top_k_select_if.sv | 27 ++
 rtl/top_k_select.sv | 125 ++++++++++++
 tb/tb_top_k_select.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/top_k_select_if.sv
// Candidate stream from the distance unit into the top-K selector.
interface top_k_select_if #(
  parameter int B   = 16,
  parameter int IDW = 10
) ();
  logic           dist_valid;
  logic           dist_ready;
  logic [B-1:0]   dist_in;
  logic [IDW-1:0] dist_id;
  logic           dist_last;

  modport master (
    output dist_valid,
    output dist_in,
    output dist_id,
    output dist_last,
    input  dist_ready
  );

  modport slave (
    input  dist_valid,
    input  dist_in,
    input  dist_id,
    input  dist_last,
    output dist_ready
  );
endinterface

// File: rtl/top_k_select.sv
// Streaming top-K selector: keeps the K smallest distances of a query
// in a sorted list and reports the K-th one at end of query.
module top_k_select #(
  parameter int B   = 16,
  parameter int K   = 8,
  parameter int IDW = 10,
  localparam int CW = $clog2(K+1)
) (
  input  logic           clk,
  input  logic           rst,
  top_k_select_if.slave  s,
  output logic           top_k_done,
  output logic [B-1:0]   kth_distance,
  output logic [IDW-1:0] kth_id,
  output logic [CW-1:0]  cand_count
);

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t         state_q;
  logic           ready_q;
  logic           done_q;
  logic [B-1:0]   kth_dist_q;
  logic [IDW-1:0] kth_id_q;
  logic [CW-1:0]  cnt_q;

  logic [B-1:0]   dist_q [K];
  logic [IDW-1:0] id_q   [K];
  logic [K-1:0]   vld_q;
  logic [B-1:0]   dist_d [K];
  logic [IDW-1:0] id_d   [K];
  logic [K-1:0]   vld_d;

  logic           accept;
  int             p;
  int             nxt_cnt;
  logic [B-1:0]   nxt_dist;
  logic [IDW-1:0] nxt_id;

  assign s.dist_ready  = ready_q;
  assign top_k_done    = done_q;
  assign kth_distance  = kth_dist_q;
  assign kth_id        = kth_id_q;
  assign cand_count    = cnt_q;

  always_comb begin
    accept = s.dist_valid & ready_q;
    // Equal entries count toward p, so ties land after older ones
    p = 0;
    for (int i = 0; i < K; i++) begin
      if (vld_q[i] && dist_q[i] <= s.dist_in) p = p + 1;
    end
    dist_d = dist_q;
    id_d   = id_q;
    vld_d  = vld_q;
    if (accept && p < K) begin
      for (int i = 0; i < K; i++) begin
        if (i == p) begin
          dist_d[i] = s.dist_in;
          id_d[i]   = s.dist_id;
          vld_d[i]  = 1'b1;
        end
      end
      for (int i = 1; i < K; i++) begin
        if (i > p) begin
          dist_d[i] = dist_q[i-1];
          id_d[i]   = id_q[i-1];
          vld_d[i]  = vld_q[i-1];
        end
      end
    end
    nxt_cnt  = 0;
    nxt_dist = '0;
    nxt_id   = '0;
    for (int i = 0; i < K; i++) begin
      if (vld_d[i]) begin
        nxt_cnt  = nxt_cnt + 1;
        nxt_dist = dist_d[i];
        nxt_id   = id_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    dist_q <= dist_d;
    id_q   <= id_d;
  end

  // Result registers load on the accepting edge so they
  // appear together with the done pulse in the FLUSH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      kth_dist_q <= '0;
      kth_id_q   <= '0;
      cnt_q      <= '0;
      vld_q      <= '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          vld_q   <= vld_d;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          if (accept && s.dist_last) begin
            state_q    <= FLUSH;
            ready_q    <= 1'b0;
            done_q     <= 1'b1;
            kth_dist_q <= nxt_dist;
            kth_id_q   <= nxt_id;
            cnt_q      <= CW'(nxt_cnt);
          end
        end
        FLUSH: begin
          vld_q   <= '0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_k_select.sv
// Scoreboard bench for top_k_select with K=4, K=2 and K=1 instances.
module tb_top_k_select;

  typedef struct {
    logic [15:0] d;
    logic [9:0]  id;
    logic [3:0]  c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid [3];
  logic [15:0] din   [3];
  logic [9:0]  did   [3];
  logic        last  [3];
  logic        rdy   [3];
  logic        done  [3];
  logic [15:0] kd    [3];
  logic [9:0]  ki    [3];
  logic [3:0]  cc    [3];
  logic [2:0]  c4;
  logic [1:0]  c2;
  logic [0:0]  c1;

  int tests = 0;
  int fails = 0;
  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;

  top_k_select_if #(.B(16), .IDW(10)) if4 ();
  top_k_select_if #(.B(16), .IDW(10)) if2 ();
  top_k_select_if #(.B(16), .IDW(10)) if1 ();

  assign if4.dist_valid = valid[0];
  assign if4.dist_in    = din[0];
  assign if4.dist_id    = did[0];
  assign if4.dist_last  = last[0];
  assign rdy[0]         = if4.dist_ready;
  assign if2.dist_valid = valid[1];
  assign if2.dist_in    = din[1];
  assign if2.dist_id    = did[1];
  assign if2.dist_last  = last[1];
  assign rdy[1]         = if2.dist_ready;
  assign if1.dist_valid = valid[2];
  assign if1.dist_in    = din[2];
  assign if1.dist_id    = did[2];
  assign if1.dist_last  = last[2];
  assign rdy[2]         = if1.dist_ready;
  assign cc[0] = 4'(c4);
  assign cc[1] = 4'(c2);
  assign cc[2] = 4'(c1);

  top_k_select #(.B(16), .K(4), .IDW(10)) u4 (
    .clk(clk), .rst(rst), .s(if4.slave),
    .top_k_done(done[0]), .kth_distance(kd[0]),
    .kth_id(ki[0]), .cand_count(c4)
  );
  top_k_select #(.B(16), .K(2), .IDW(10)) u2 (
    .clk(clk), .rst(rst), .s(if2.slave),
    .top_k_done(done[1]), .kth_distance(kd[1]),
    .kth_id(ki[1]), .cand_count(c2)
  );
  top_k_select #(.B(16), .K(1), .IDW(10)) u1 (
    .clk(clk), .rst(rst), .s(if1.slave),
    .top_k_done(done[2]), .kth_distance(kd[2]),
    .kth_id(ki[2]), .cand_count(c1)
  );

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [15:0] d,
                      input logic [9:0] id, input logic [3:0] c);
    exp_t e;
    e.d = d; e.id = id; e.c = c;
    if (k == 0) q0.push_back(e);
    else if (k == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  task automatic chk(input string nm, input int k, input exp_t e);
    cmp({nm, "_kth_distance"}, 32'(kd[k]), 32'(e.d));
    cmp({nm, "_kth_id"}, 32'(ki[k]), 32'(e.id));
    cmp({nm, "_cand_count"}, 32'(cc[k]), 32'(e.c));
  endtask

  always @(negedge clk) begin
    if (done[0]) begin
      if (q0.size() == 0) cmp("k4_spurious_done", 1, 0);
      else begin e0 = q0.pop_front(); chk("k4", 0, e0); end
    end
  end
  always @(negedge clk) begin
    if (done[1]) begin
      if (q1.size() == 0) cmp("k2_spurious_done", 1, 0);
      else begin e1 = q1.pop_front(); chk("k2", 1, e1); end
    end
  end
  always @(negedge clk) begin
    if (done[2]) begin
      if (q2.size() == 0) cmp("k1_spurious_done", 1, 0);
      else begin e2 = q2.pop_front(); chk("k1", 2, e2); end
    end
  end

  task automatic send(input int k, input logic [15:0] d,
                      input logic [9:0] id, input logic l,
                      output int w);
    valid[k] = 1'b1; din[k] = d; did[k] = id; last[k] = l;
    w = 0;
    while (!rdy[k] && w < 16) begin
      @(negedge clk);
      w++;
    end
    if (!rdy[k]) begin
      cmp("send_timeout", 1, 0);
      valid[k] = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  int w;
  logic [15:0] v1 [6];
  logic [15:0] v2;

  initial begin
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0; din[k] = '0; did[k] = '0; last[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cmp("rst_done", 32'(done[k]), 0);
      cmp("rst_kth_distance", 32'(kd[k]), 0);
      cmp("rst_kth_id", 32'(ki[k]), 0);
      cmp("rst_cand_count", 32'(cc[k]), 0);
      cmp("rst_ready", 32'(rdy[k]), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    cmp("ready_after_rst", 32'(rdy[0]), 1);

    // 9,3,7,1,5,8 -> list 1,3,5,7
    v1[0] = 9; v1[1] = 3; v1[2] = 7; v1[3] = 1; v1[4] = 5; v1[5] = 8;
    push(0, 16'd7, 10'd2, 4'd4);
    for (int i = 0; i < 6; i++) send(0, v1[i], 10'(i), i == 5, w);
    cmp("k4_done_latency", 32'(done[0]), 1);
    cmp("k4_ready_bubble", 32'(rdy[0]), 0);
    valid[0] = 1'b0;
    @(negedge clk);
    cmp("k4_ready_back", 32'(rdy[0]), 1);
    cmp("k4_done_one_cycle", 32'(done[0]), 0);

    // short query, then a lone candidate proves the list was cleared
    push(0, 16'd20, 10'd1, 4'd2);
    send(0, 16'd10, 10'd0, 1'b0, w);
    send(0, 16'd20, 10'd1, 1'b1, w);
    push(0, 16'd30, 10'd7, 4'd1);
    send(0, 16'd30, 10'd7, 1'b1, w);
    valid[0] = 1'b0;
    repeat (2) @(negedge clk);

    // ties with K=2
    push(1, 16'd5, 10'd1, 4'd2);
    send(1, 16'd5, 10'd0, 1'b0, w);
    send(1, 16'd5, 10'd1, 1'b0, w);
    send(1, 16'd5, 10'd2, 1'b1, w);
    valid[1] = 1'b0;
    repeat (2) @(negedge clk);

    // back-to-back queries with valid held high
    push(0, 16'd6, 10'd3, 4'd3);
    send(0, 16'd4, 10'd1, 1'b0, w);
    send(0, 16'd2, 10'd2, 1'b0, w);
    send(0, 16'd6, 10'd3, 1'b1, w);
    push(0, 16'd50, 10'd4, 4'd2);
    send(0, 16'd50, 10'd4, 1'b0, w);
    cmp("b2b_bubble_cycles", 32'(w), 1);
    send(0, 16'd40, 10'd5, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      push(0, 16'(11 + i), 10'(20 + i), 4'd1);
      send(0, 16'(11 + i), 10'(20 + i), 1'b1, w);
      if (i > 0) cmp("single_b2b_bubble", 32'(w), 1);
    end
    valid[0] = 1'b0;
    repeat (2) @(negedge clk);

    // async reset mid-query discards the partial list
    send(0, 16'd1, 10'd0, 1'b0, w);
    send(0, 16'd2, 10'd1, 1'b0, w);
    send(0, 16'd3, 10'd2, 1'b0, w);
    valid[0] = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    cmp("midq_rst_done", 32'(done[0]), 0);
    cmp("midq_rst_kth_distance", 32'(kd[0]), 0);
    cmp("midq_rst_cand_count", 32'(cc[0]), 0);
    cmp("midq_rst_ready", 32'(rdy[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    push(0, 16'd4, 10'd1, 4'd2);
    send(0, 16'd2, 10'd0, 1'b0, w);
    send(0, 16'd4, 10'd1, 1'b1, w);
    valid[0] = 1'b0;
    repeat (2) @(negedge clk);

    // reset landing in the FLUSH cycle aborts the pulse
    valid[2] = 1'b1; din[2] = 16'd7; did[2] = 10'd9; last[2] = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    valid[2] = 1'b0;
    @(negedge clk);
    cmp("flush_rst_done", 32'(done[2]), 0);
    cmp("flush_rst_kth_distance", 32'(kd[2]), 0);
    cmp("flush_rst_cand_count", 32'(cc[2]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // full-scale values with K=1
    v2 = '1;
    push(2, 16'd0, 10'd4, 4'd1);
    send(2, v2, 10'd3, 1'b0, w);
    send(2, 16'd0, 10'd4, 1'b1, w);
    push(2, v2, 10'd6, 4'd1);
    send(2, v2, 10'd6, 1'b1, w);
    valid[2] = 1'b0;
    repeat (3) @(negedge clk);

    cmp("k4_queue_drained", 32'(q0.size()), 0);
    cmp("k2_queue_drained", 32'(q1.size()), 0);
    cmp("k1_queue_drained", 32'(q2.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
